// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: instruction-side fetch responder.
// Converts the core's byte PC into a word address, runs a req/ack handshake with
// instruction memory, and returns the fetched word with a one-cycle rom_rdy pulse.
// Misaligned, out-of-range and timed-out fetches raise a sticky fault that only
// a reset clears.
module rom_fetch_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          AW        = 12,
    parameter int          TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic [31:0]   pc,
    output logic [31:0]   instr,
    output logic          rom_rdy,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          fault,
    output logic [1:0]    fault_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } fetchState_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] DEPTH_WORDS = 32'd1 << AW;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISALIGN = 2'd1;
    localparam logic [1:0] CODE_RANGE    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

    fetchState_e r_state;
    fetchState_e w_stateNext;

    logic [31:0]   r_instr;
    logic          r_romRdy;
    logic          r_memReq;
    logic [AW-1:0] r_memAddr;
    logic          r_fault;
    logic [1:0]    r_faultCode;
    logic [7:0]    r_cnt;

    logic [31:0]   w_instrNext;
    logic          w_romRdyNext;
    logic          w_memReqNext;
    logic [AW-1:0] w_memAddrNext;
    logic          w_faultNext;
    logic [1:0]    w_faultCodeNext;
    logic [7:0]    w_cntNext;

    logic [31:0]   w_offset;
    logic [31:0]   w_wordOff;
    logic [AW-1:0] w_wordIdx;
    logic          w_below;
    logic [1:0]    w_chkCode;
    logic [7:0]    w_cntInc;

    // Address check on the live pc: unsigned offset from the base, where any
    // pc below the base counts as out of range rather than wrapping around.
    assign w_offset  = pc - BASE_ADDR;
    assign w_wordOff = w_offset >> 2;
    assign w_wordIdx = w_wordOff[AW-1:0];
    assign w_below   = (pc < BASE_ADDR);
    assign w_cntInc  = r_cnt + 8'd1;

    // Misalignment takes precedence over the range check.
    always_comb begin
        w_chkCode = CODE_NONE;
        if (pc[1:0] != 2'b00) begin
            w_chkCode = CODE_MISALIGN;
        end else if (w_below || (w_wordOff >= DEPTH_WORDS)) begin
            w_chkCode = CODE_RANGE;
        end
    end

    // State and registered outputs; reset drops everything immediately, so an
    // in-flight request is simply abandoned.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_instr     <= NOP_INSTR;
            r_romRdy    <= 1'b0;
            r_memReq    <= 1'b0;
            r_memAddr   <= '0;
            r_fault     <= 1'b0;
            r_faultCode <= CODE_NONE;
            r_cnt       <= 8'd0;
        end else begin
            r_state     <= w_stateNext;
            r_instr     <= w_instrNext;
            r_romRdy    <= w_romRdyNext;
            r_memReq    <= w_memReqNext;
            r_memAddr   <= w_memAddrNext;
            r_fault     <= w_faultNext;
            r_faultCode <= w_faultCodeNext;
            r_cnt       <= w_cntNext;
        end
    end

    // Next-state: IDLE and DONE both launch a fetch of the current pc, REQ
    // waits for ack or timeout, and FAULT is terminal until reset.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE, DONE: begin
                w_stateNext = (w_chkCode == CODE_NONE) ? REQ : FAULT;
            end
            REQ: begin
                if (mem_ack) begin
                    w_stateNext = DONE;
                end else if (w_cntInc == TIMEOUT_CNT) begin
                    w_stateNext = FAULT;
                end
            end
            FAULT: begin
                w_stateNext = FAULT;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs; instr only changes on an ack
    // in REQ, so it holds the last good word through DONE and FAULT.
    always_comb begin
        w_instrNext     = r_instr;
        w_romRdyNext    = 1'b0;
        w_memReqNext    = r_memReq;
        w_memAddrNext   = r_memAddr;
        w_faultNext     = r_fault;
        w_faultCodeNext = r_faultCode;
        w_cntNext       = r_cnt;
        case (r_state)
            IDLE, DONE: begin
                if (w_chkCode == CODE_NONE) begin
                    w_memReqNext  = 1'b1;
                    w_memAddrNext = w_wordIdx;
                    w_cntNext     = 8'd0;
                end else begin
                    w_memReqNext    = 1'b0;
                    w_faultNext     = 1'b1;
                    w_faultCodeNext = w_chkCode;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_instrNext  = mem_rdata;
                    w_memReqNext = 1'b0;
                    w_romRdyNext = 1'b1;
                end else begin
                    w_cntNext = w_cntInc;
                    if (w_cntInc == TIMEOUT_CNT) begin
                        w_memReqNext    = 1'b0;
                        w_faultNext     = 1'b1;
                        w_faultCodeNext = CODE_TIMEOUT;
                    end
                end
            end
            FAULT: begin
                w_memReqNext = 1'b0;
            end
            default: begin
                w_memReqNext = 1'b0;
            end
        endcase
    end

    assign instr      = r_instr;
    assign rom_rdy    = r_romRdy;
    assign mem_req    = r_memReq;
    assign mem_addr   = r_memAddr;
    assign fault      = r_fault;
    assign fault_code = r_faultCode;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: directed and randomized fetches against a transaction-level
// model of the fetch controller, with the bench playing instruction memory.
module tb_rom_fetch_ctrl;

    localparam logic [31:0] BASE       = 32'h0040_0000;
    localparam int          AW         = 12;
    localparam int          DEPTH      = 4096;
    localparam int          TB_TIMEOUT = 8;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic          clk;
    logic          sys_rst_n;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          rom_rdy;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          fault;
    logic [1:0]    fault_code;

    int checks = 0;
    int errors = 0;

    logic [31:0] romImage [DEPTH];
    logic [31:0] expInstr;
    logic        faulted;
    logic [31:0] pcCur;

    rom_fetch_ctrl #(
        .BASE_ADDR (BASE),
        .AW        (AW),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .pc         (pc),
        .instr      (instr),
        .rom_rdy    (rom_rdy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected fault code for a pc from the address rules alone.
    function automatic logic [1:0] classifyPc(input logic [31:0] p);
        if (p % 4 != 0) return 2'd1;
        if (p < BASE) return 2'd2;
        if ((p - BASE) / 4 >= DEPTH) return 2'd2;
        return 2'd0;
    endfunction

    // Asynchronous reset: outputs must drop before any clock edge arrives.
    task automatic applyReset();
        @(posedge clk); #1;
        sys_rst_n = 1'b0;
        mem_ack   = 1'b0;
        #2;
        checkOutput("rst_mem_req",    {31'd0, mem_req},   32'd0);
        checkOutput("rst_rom_rdy",    {31'd0, rom_rdy},   32'd0);
        checkOutput("rst_fault",      {31'd0, fault},     32'd0);
        checkOutput("rst_fault_code", {30'd0, fault_code}, 32'd0);
        checkOutput("rst_instr",      instr,              NOP);
        checkOutput("rst_mem_addr",   {20'd0, mem_addr},  32'd0);
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        expInstr  = NOP;
        faulted   = 1'b0;
    endtask

    // One fetch transaction. Must be called when the next edge launches a
    // check (IDLE just after reset release, or during the DONE cycle).
    // The memory acks after 'waits' stall cycles; waits >= TIMEOUT times out.
    task automatic applyStimulus(input logic [31:0] pcVal, input int waits);
        logic [1:0]  code;
        logic [31:0] idx;
        logic [31:0] word;
        bit          ended;
        code  = classifyPc(pcVal);
        idx   = (pcVal - BASE) / 4;
        word  = (code == 2'd0) ? romImage[idx[AW-1:0]] : 32'd0;
        ended = 1'b0;
        pc        = pcVal;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checkOutput("chk_rom_rdy_low", {31'd0, rom_rdy}, 32'd0);
        if (code != 2'd0) begin
            checkOutput("addr_fault",      {31'd0, fault},      32'd1);
            checkOutput("addr_fault_code", {30'd0, fault_code}, {30'd0, code});
            checkOutput("addr_no_req",     {31'd0, mem_req},    32'd0);
            checkOutput("addr_instr_hold", instr,               expInstr);
            faulted = 1'b1;
            return;
        end
        checkOutput("req_mem_req",  {31'd0, mem_req}, 32'd1);
        checkOutput("req_mem_addr", {20'd0, mem_addr}, idx);
        checkOutput("req_no_fault", {31'd0, fault},   32'd0);
        for (int c = 0; c < TB_TIMEOUT && !ended; c++) begin
            pc = $urandom;
            if (c == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = word;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (c == waits) begin
                expInstr = word;
                checkOutput("done_rom_rdy", {31'd0, rom_rdy}, 32'd1);
                checkOutput("done_instr",   instr,            expInstr);
                checkOutput("done_mem_req", {31'd0, mem_req}, 32'd0);
                checkOutput("done_fault",   {31'd0, fault},   32'd0);
                ended = 1'b1;
            end else if (c + 1 == TB_TIMEOUT) begin
                checkOutput("to_fault",      {31'd0, fault},      32'd1);
                checkOutput("to_fault_code", {30'd0, fault_code}, 32'd3);
                checkOutput("to_mem_req",    {31'd0, mem_req},    32'd0);
                checkOutput("to_rom_rdy",    {31'd0, rom_rdy},    32'd0);
                checkOutput("to_instr_hold", instr,               expInstr);
                faulted = 1'b1;
                ended   = 1'b1;
            end else begin
                checkOutput("wait_mem_req",  {31'd0, mem_req},  32'd1);
                checkOutput("wait_mem_addr", {20'd0, mem_addr}, idx);
                checkOutput("wait_rom_rdy",  {31'd0, rom_rdy},  32'd0);
            end
        end
    endtask

    // A fault must survive any pc or ack activity until reset.
    task automatic checkSticky(input logic [1:0] code);
        for (int k = 0; k < 3; k++) begin
            pc        = $urandom;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(posedge clk); #1;
            checkOutput("sticky_fault", {31'd0, fault},      32'd1);
            checkOutput("sticky_code",  {30'd0, fault_code}, {30'd0, code});
            checkOutput("sticky_req",   {31'd0, mem_req},    32'd0);
            checkOutput("sticky_rdy",   {31'd0, rom_rdy},    32'd0);
            checkOutput("sticky_instr", instr,               expInstr);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        int          kind;
        int          waits;
        logic [31:0] p;
        sys_rst_n = 1'b0;
        pc        = BASE;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        expInstr  = NOP;
        faulted   = 1'b0;
        for (int i = 0; i < DEPTH; i++) romImage[i] = $urandom;
        romImage[0] = 32'h0000_0093;

        $display("[TB] T1 first fetch after reset");
        applyReset();
        applyStimulus(BASE, 0);

        $display("[TB] T2 sequential fetches with 3 wait cycles");
        for (int i = 1; i < 4; i++) applyStimulus(BASE + 32'(4 * i), 3);

        $display("[TB] T3 misaligned pc after DONE");
        applyStimulus(BASE + 32'h12, 0);
        checkSticky(2'd1);

        $display("[TB] T4 out-of-range pcs");
        applyReset();
        applyStimulus(32'h003F_FFFC, 0);
        checkSticky(2'd2);
        applyReset();
        applyStimulus(BASE + 32'(DEPTH * 4), 0);
        checkSticky(2'd2);

        $display("[TB] T5 timeout with ack held low");
        applyReset();
        applyStimulus(BASE, TB_TIMEOUT);
        checkSticky(2'd3);

        $display("[TB] last word with ack one cycle before timeout");
        applyReset();
        applyStimulus(BASE + 32'((DEPTH - 1) * 4), TB_TIMEOUT - 1);

        $display("[TB] T6 reset mid-request");
        pc      = BASE + 32'd8;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        checkOutput("t6_req",  {31'd0, mem_req},  32'd1);
        checkOutput("t6_addr", {20'd0, mem_addr}, 32'd2);
        @(posedge clk); #1;
        checkOutput("t6_req_wait", {31'd0, mem_req}, 32'd1);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("t6_req_drop",   {31'd0, mem_req}, 32'd0);
        checkOutput("t6_rdy_drop",   {31'd0, rom_rdy}, 32'd0);
        checkOutput("t6_fault_drop", {31'd0, fault},   32'd0);
        checkOutput("t6_instr_nop",  instr,            NOP);
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        expInstr  = NOP;
        applyStimulus(BASE + 32'd8, 1);

        $display("[TB] randomized fetch stream");
        pcCur = BASE + 32'd12;
        for (int n = 0; n < 60; n++) begin
            kind  = $urandom_range(0, 19);
            waits = $urandom_range(0, TB_TIMEOUT - 1);
            case (kind)
                0: p = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
                1: p = BASE - 32'($urandom_range(1, 4096) * 4);
                2: p = BASE + 32'((DEPTH + $urandom_range(0, 1000)) * 4);
                3: begin p = pcCur; waits = TB_TIMEOUT + 2; end
                4: p = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
                default: p = pcCur;
            endcase
            applyStimulus(p, waits);
            if (faulted) begin
                checkSticky(fault_code === 2'd0 ? classifyPc(p) : (classifyPc(p) != 2'd0 ? classifyPc(p) : 2'd3));
                applyReset();
                pcCur = BASE;
            end else begin
                pcCur = p + 32'd4;
                if (classifyPc(pcCur) != 2'd0) pcCur = BASE;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
